// File: rtl/prog_mem_loader.sv
// Instruction-memory writer: streams words over valid/ready into a 32x9 RAM at
// consecutive addresses and exposes a registered, ROM-compatible read port.
module prog_mem_loader #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrValid,
  input  logic              WrLast,
  output logic              WrReady,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              Busy,
  output logic              LoadDone,
  output logic [ADDR_W:0]   WordCount,
  output logic              Overflow,
  output logic [1:0]        DbgState
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: a word is transferred on a rising edge where WrValid and
  // WrReady are both 1. WrReady depends only on state, never on WrValid,
  // and WrLast/WrData are sampled only on a transfer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic xfer;
  logic last_slot;

  assign xfer      = (state_q == S_LOAD) && WrValid;
  assign last_slot = (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          count_d = count_q + (ADDR_W + 1)'(1);
          // The address parks on the last slot instead of wrapping to 0.
          if (!last_slot) addr_d = addr_q + ADDR_W'(1);
          if (WrLast) begin
            state_d = S_DONE;
          end else if (last_slot) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_data_q <= mem[RdAddr];
    end
  end

  // RAM array has no reset so program contents survive a Resetn pulse.
  always_ff @(posedge Clock) begin
    if (xfer) mem[addr_q] <= WrData;
  end

  assign WrReady   = (state_q == S_LOAD);
  assign Busy      = (state_q == S_LOAD);
  assign LoadDone  = (state_q == S_DONE);
  assign WordCount = count_q;
  assign Overflow  = ovf_q;
  assign RdData    = rd_data_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed plus randomized bench for prog_mem_loader against a word-level
// model of the program memory and load status.
module tb_prog_mem_loader;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic [8:0] WrData = '0;
  logic       WrValid = 1'b0;
  logic       WrLast = 1'b0;
  logic [4:0] RdAddr = '0;
  logic       WrReady, Busy, LoadDone, Overflow;
  logic [8:0] RdData;
  logic [5:0] WordCount;
  logic [1:0] DbgState;

  prog_mem_loader #(.DATA_W(9), .ADDR_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .WrData(WrData),
    .WrValid(WrValid), .WrLast(WrLast), .WrReady(WrReady), .RdAddr(RdAddr),
    .RdData(RdData), .Busy(Busy), .LoadDone(LoadDone), .WordCount(WordCount),
    .Overflow(Overflow), .DbgState(DbgState)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: program image plus load status.
  logic [8:0] m_mem [32];
  bit         m_written [32];
  bit         m_loading, m_done, m_ovf;
  int         m_count;
  logic [8:0] m_rd;
  bit         m_rd_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".wr_ready"}, 32'(WrReady), 32'(m_loading));
    check({tag, ".busy"}, 32'(Busy), 32'(m_loading));
    check({tag, ".load_done"}, 32'(LoadDone), 32'(m_done));
    check({tag, ".word_count"}, 32'(WordCount), m_count);
    check({tag, ".overflow"}, 32'(Overflow), 32'(m_ovf));
    if (m_rd_known) check({tag, ".rd_data"}, 32'(RdData), 32'(m_rd));
  endtask

  task automatic model_reset();
    m_loading  = 0;
    m_done     = 0;
    m_ovf      = 0;
    m_count    = 0;
    m_rd       = '0;
    m_rd_known = 1;
  endtask

  // One clock: drive inputs, advance model on the edge, release pulses.
  task automatic step(input bit v, input logic [8:0] d, input bit l, input bit s,
                      input logic [4:0] ra);
    WrValid = v; WrData = d; WrLast = l; Start = s; RdAddr = ra;
    @(posedge Clock);
    m_rd       = m_mem[ra];
    m_rd_known = m_written[ra];
    if (m_loading) begin
      if (v) begin
        m_mem[m_count]     = d;
        m_written[m_count] = 1;
        m_count++;
        if (l) begin
          m_loading = 0; m_done = 1;
        end else if (m_count == 32) begin
          m_loading = 0; m_done = 1; m_ovf = 1;
        end
      end
    end else if (s) begin
      m_loading = 1; m_done = 0; m_count = 0; m_ovf = 0;
    end
    @(negedge Clock);
    WrValid = 0; Start = 0; WrLast = 0;
  endtask

  task automatic do_reset(input string tag);
    #2 Resetn = 0;
    model_reset();
    #1 check_state(tag);
    check({tag, ".rd_zero"}, 32'(RdData), 32'h0);
    @(negedge Clock);
    Resetn = 1;
  endtask

  task automatic readback(input string tag, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      step(0, '0, 0, 0, 5'(a));
      check_state($sformatf("%s.rd%0d", tag, a));
    end
  endtask

  logic [8:0] t1_words [4] = '{9'h1C0, 9'h041, 9'h0A2, 9'h1FF};
  logic [8:0] first_word;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin m_written[i] = 0; m_mem[i] = 'x; end
    model_reset();
    @(negedge Clock);
    do_reset("reset");

    // 1: four-word program
    step(0, '0, 0, 1, '0);
    check_state("t1.start");
    for (int i = 0; i < 4; i++) begin
      step(1, t1_words[i], i == 3, 0, '0);
      check_state($sformatf("t1.w%0d", i));
    end
    check("t1.done", 32'(LoadDone), 32'h1);
    check("t1.count", 32'(WordCount), 32'd4);
    for (int a = 0; a < 4; a++) begin
      step(0, '0, 0, 0, 5'(a));
      check($sformatf("t1.rd%0d", a), 32'(RdData), 32'(t1_words[a]));
    end

    // 2: valid gaps and an ignored mid-load Start
    step(0, '0, 0, 1, '0);
    step(1, 9'h011, 0, 0, '0);
    step(0, 9'h1EE, 1, 1, '0);
    check_state("t2.midstart");
    step(0, 9'h1EE, 0, 0, '0);
    step(1, 9'h022, 0, 0, '0);
    step(1, 9'h033, 1, 0, '0);
    check_state("t2.end");
    check("t2.count", 32'(WordCount), 32'd3);
    readback("t2", 0, 3);

    // 3: full memory without WrLast overflows
    step(0, '0, 0, 1, '0);
    first_word = 9'($urandom);
    for (int i = 0; i < 32; i++) step(1, i == 0 ? first_word : 9'($urandom), 0, 0, '0);
    check_state("t3.full");
    check("t3.ovf", 32'(Overflow), 32'h1);
    check("t3.count", 32'(WordCount), 32'd32);
    step(1, 9'h1AB, 0, 0, '0);
    check_state("t3.extra");
    step(0, '0, 0, 0, 5'd0);
    check("t3.mem0", 32'(RdData), 32'(first_word));

    // 4: full memory with WrLast on the final word
    step(0, '0, 0, 1, '0);
    check("t4.ovf_clr", 32'(Overflow), 32'h0);
    for (int i = 0; i < 32; i++) step(1, 9'($urandom), i == 31, 0, '0);
    check_state("t4.full");
    check("t4.done", 32'(LoadDone), 32'h1);
    readback("t4", 0, 31);

    // 5: read-before-write on the same address
    step(0, '0, 0, 1, '0);
    for (int i = 0; i < 5; i++) step(1, 9'($urandom), 0, 0, '0);
    step(1, 9'h0AA, 1, 0, '0);
    step(0, '0, 0, 1, '0);
    for (int i = 0; i < 5; i++) step(1, 9'($urandom), 0, 0, '0);
    step(1, 9'h155, 1, 0, 5'd5);
    check("t5.old", 32'(RdData), 32'h0AA);
    step(0, '0, 0, 0, 5'd5);
    check("t5.new", 32'(RdData), 32'h155);

    // 6: reset mid-load, then Start from DONE after overflow
    step(0, '0, 0, 1, '0);
    step(1, 9'h0F0, 0, 0, '0);
    step(1, 9'h10F, 0, 0, '0);
    do_reset("t6.reset");
    readback("t6", 0, 1);
    step(0, '0, 0, 1, '0);
    for (int i = 0; i < 32; i++) step(1, 9'($urandom), 0, 0, '0);
    check("t6.ovf", 32'(Overflow), 32'h1);
    step(0, '0, 0, 1, '0);
    check_state("t6.restart");
    step(1, 9'h07E, 1, 0, '0);
    step(0, '0, 0, 0, 5'd0);
    check("t6.addr0", 32'(RdData), 32'h07E);

    // Randomized loads with gaps, stray Starts and random read addresses
    for (int n = 0; n < 8; n++) begin
      int len;
      bit use_last;
      len = $urandom_range(1, 32);
      use_last = (len < 32) || ($urandom_range(0, 1) == 1);
      step(0, '0, 0, 1, 5'($urandom));
      for (int i = 0; i < len; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          step(0, 9'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
          check_state($sformatf("rnd%0d.gap", n));
        end
        step(1, 9'($urandom), use_last && (i == len - 1), 0, 5'($urandom));
        check_state($sformatf("rnd%0d.w%0d", n, i));
      end
      step(1, 9'($urandom), 0, 0, 5'($urandom));
      check_state($sformatf("rnd%0d.after", n));
      readback($sformatf("rnd%0d", n), 0, 31);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
